ifid_pipe: RTL and testbench



---
 rtl/ifid_pipe_pkg.sv | 33 +++
 rtl/ifid_pipe_sat_counter.sv | 26 ++
 rtl/ifid_pipe.sv | 125 ++++++++++++
 tb/tb_ifid_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ifid_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_pipe_pkg
// Purpose  : Constants and types shared by the IF/ID register, the hazard unit
//            and the decoder of the 16-bit 5-stage core.
// Revision : 1.0 - initial release
// ============================================================================
package ifid_pipe_pkg;

    // Encoding injected into IF/ID on flush, fetch bubble and reset
    localparam logic [15:0] C_NOP_INSTR = 16'h0800;

    // Opcode that stops fetch once it has been accepted into decode
    localparam logic [4:0]  C_HALT_OPC  = 5'b00000;

    // Location of the opcode field inside an instruction word
    localparam int C_OPC_MSB = 15;
    localparam int C_OPC_LSB = 11;

    // IF/ID control states; HOLD only marks a stalled cycle
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } ifid_state_e;

    // Extract the opcode field of an instruction
    function automatic logic [4:0] opcode_of(input logic [15:0] instr);
        return instr[C_OPC_MSB:C_OPC_LSB];
    endfunction

endpackage : ifid_pipe_pkg
`default_nettype wire

// File: rtl/ifid_pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count requested events until the counter reaches its maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/ifid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ifid_pipe
// Purpose  : IF/ID pipeline register with stall/flush/bubble handling, HALT
//            detection and saturating stall/bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_pipe
    import ifid_pipe_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = C_NOP_INSTR,
    parameter logic [4:0]  HALT_OPC  = C_HALT_OPC,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      if_instr,
    input  logic [15:0]      if_PC,
    input  logic [15:0]      if_pcPlus2,
    input  logic             imem_ready,
    input  logic             ifid_write,
    input  logic             flush,
    output logic [15:0]      ifid_instr,
    output logic [15:0]      ifid_PC,
    output logic [15:0]      ifid_pcPlus2,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    ifid_state_e r_state;
    logic        w_stall_inc;
    logic        w_bubble_inc;
    logic        w_is_halt;

    assign w_is_halt = (opcode_of(if_instr) == HALT_OPC);

    // Decide which performance counter, if any, moves on this edge.
    // While HALTED and not yet confirmed, a flush can still squash the HALT.
    always_comb begin
        w_stall_inc  = 1'b0;
        w_bubble_inc = 1'b0;
        if (r_state == ST_HALTED) begin
            if (!halted && flush) begin
                w_bubble_inc = 1'b1;
            end
        end else if (flush) begin
            w_bubble_inc = 1'b1;
        end else if (!ifid_write) begin
            w_stall_inc = 1'b1;
        end else if (!imem_ready) begin
            w_bubble_inc = 1'b1;
        end
    end

    // Pipeline register and control FSM. A HALT loaded into ID moves the FSM
    // to HALTED; the halted flag rises one edge later unless a flush squashes
    // the HALT on that edge, in which case the FSM returns to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            ifid_instr   <= NOP_INSTR;
            ifid_PC      <= '0;
            ifid_pcPlus2 <= '0;
            ifid_valid   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            case (r_state)
                ST_HALTED: begin
                    if (!halted) begin
                        if (flush) begin
                            ifid_instr <= NOP_INSTR;
                            ifid_valid <= 1'b0;
                            r_state    <= ST_RUN;
                        end else begin
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (flush) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        r_state    <= ST_RUN;
                    end else if (!ifid_write) begin
                        r_state <= ST_HOLD;
                    end else if (!imem_ready) begin
                        // Fetch data is ignored here, so X on if_instr never
                        // reaches the outputs
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        r_state    <= ST_RUN;
                    end else begin
                        ifid_instr   <= if_instr;
                        ifid_PC      <= if_PC;
                        ifid_pcPlus2 <= if_pcPlus2;
                        ifid_valid   <= 1'b1;
                        r_state      <= w_is_halt ? ST_HALTED : ST_RUN;
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_bubble_inc),
        .count (bubble_cnt)
    );

endmodule : ifid_pipe
`default_nettype wire

// File: tb/tb_ifid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifid_pipe
// Purpose  : Self-checking bench for ifid_pipe: vector table plus directed
//            sequences for HALT, asynchronous reset and counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifid_pipe;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [15:0]      if_instr;
    logic [15:0]      if_PC;
    logic [15:0]      if_pcPlus2;
    logic             imem_ready;
    logic             ifid_write;
    logic             flush;
    logic [15:0]      ifid_instr;
    logic [15:0]      ifid_PC;
    logic [15:0]      ifid_pcPlus2;
    logic             ifid_valid;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    ifid_pipe #(
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_instr     (if_instr),
        .if_PC        (if_PC),
        .if_pcPlus2   (if_pcPlus2),
        .imem_ready   (imem_ready),
        .ifid_write   (ifid_write),
        .flush        (flush),
        .ifid_instr   (ifid_instr),
        .ifid_PC      (ifid_PC),
        .ifid_pcPlus2 (ifid_pcPlus2),
        .ifid_valid   (ifid_valid),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        wr;
        logic        rdy;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic [15:0] e_pc2;
        logic        e_valid;
        logic [15:0] e_stall;
        logic [15:0] e_bubble;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                           input logic [15:0] ep2, input logic ev, input logic eh,
                           input logic [15:0] es, input logic [15:0] eb);
        chk({tag, ".instr"},  {16'h0, ifid_instr},   {16'h0, ei});
        chk({tag, ".pc"},     {16'h0, ifid_PC},      {16'h0, ep});
        chk({tag, ".pc2"},    {16'h0, ifid_pcPlus2}, {16'h0, ep2});
        chk({tag, ".valid"},  {31'h0, ifid_valid},   {31'h0, ev});
        chk({tag, ".halted"}, {31'h0, halted},       {31'h0, eh});
        chk({tag, ".stall"},  {16'h0, stall_cnt},    {16'h0, es});
        chk({tag, ".bubble"}, {16'h0, bubble_cnt},   {16'h0, eb});
    endtask

    task automatic drive(input logic f, input logic w, input logic r,
                         input logic [15:0] ins, input logic [15:0] pc);
        flush      = f;
        ifid_write = w;
        imem_ready = r;
        if_instr   = ins;
        if_PC      = pc;
        if_pcPlus2 = pc + 16'd2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        //                flush wr rdy instr     pc        e_instr   e_pc      e_pc2     v  stall bubble
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'h4123, 16'h0000, 16'h4123, 16'h0000, 16'h0002, 1'b1, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h1111, 16'h0002, 16'h4123, 16'h0000, 16'h0002, 1'b1, 16'd1, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h2222, 16'h0004, 16'h4123, 16'h0000, 16'h0002, 1'b1, 16'd2, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h3333, 16'h0006, 16'h4123, 16'h0000, 16'h0002, 1'b1, 16'd3, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h5A5A, 16'h0008, 16'h5A5A, 16'h0008, 16'h000A, 1'b1, 16'd3, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h6666, 16'h000A, 16'h0800, 16'h0008, 16'h000A, 1'b0, 16'd3, 16'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h7777, 16'h000C, 16'h7777, 16'h000C, 16'h000E, 1'b1, 16'd3, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'hxxxx, 16'h000E, 16'h0800, 16'h000C, 16'h000E, 1'b0, 16'd3, 16'd2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'hxxxx, 16'h0010, 16'h0800, 16'h000C, 16'h000E, 1'b0, 16'd3, 16'd3};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'hxxxx, 16'h0012, 16'h0800, 16'h000C, 16'h000E, 1'b0, 16'd3, 16'd4};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h8123, 16'h0010, 16'h8123, 16'h0010, 16'h0012, 1'b1, 16'd3, 16'd4};

        drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        do_reset();
        chk_all("reset", 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, 16'd0);

        // Table: load, stall, flush-over-stall, fetch bubbles
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].flush, vecs[i].wr, vecs[i].rdy, vecs[i].instr, vecs[i].pc);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc2,
                    vecs[i].e_valid, 1'b0, vecs[i].e_stall, vecs[i].e_bubble);
            chk($sformatf("vec%0d.nox", i), {31'h0, $isunknown(ifid_instr)}, 32'h0);
        end

        // HALT squashed by a flush on the following edge
        drive(1'b0, 1'b1, 1'b1, 16'h0123, 16'h0020);
        step();
        chk_all("hsq_load", 16'h0123, 16'h0020, 16'h0022, 1'b1, 1'b0, 16'd3, 16'd4);
        drive(1'b1, 1'b1, 1'b1, 16'h1234, 16'h0022);
        step();
        chk_all("hsq_flush", 16'h0800, 16'h0020, 16'h0022, 1'b0, 1'b0, 16'd3, 16'd5);
        drive(1'b0, 1'b1, 1'b1, 16'h4444, 16'h0040);
        step();
        chk_all("hsq_resume", 16'h4444, 16'h0040, 16'h0042, 1'b1, 1'b0, 16'd3, 16'd5);

        // HALT taken: halted rises next edge, then everything freezes
        drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0030);
        step();
        chk_all("halt_load", 16'h0000, 16'h0030, 16'h0032, 1'b1, 1'b0, 16'd3, 16'd5);
        drive(1'b0, 1'b1, 1'b1, 16'h9999, 16'h0032);
        step();
        chk_all("halt_set", 16'h0000, 16'h0030, 16'h0032, 1'b1, 1'b1, 16'd3, 16'd5);
        drive(1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0034);
        step();
        chk_all("halt_frz1", 16'h0000, 16'h0030, 16'h0032, 1'b1, 1'b1, 16'd3, 16'd5);
        drive(1'b0, 1'b1, 1'b1, 16'hBBBB, 16'h0036);
        step();
        chk_all("halt_frz2", 16'h0000, 16'h0030, 16'h0032, 1'b1, 1'b1, 16'd3, 16'd5);

        // Asynchronous reset mid-cycle while HALTED, checked before any edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stall counter saturation: 65540 held cycles
        drive(1'b0, 1'b0, 1'b1, 16'h4321, 16'h0050);
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat.stall", {16'h0, stall_cnt}, 32'h0000_FFFF);
        chk("sat.bubble", {16'h0, bubble_cnt}, 32'h0);
        chk("sat.instr", {16'h0, ifid_instr}, 32'h0000_0800);
        step();
        chk("sat.stall2", {16'h0, stall_cnt}, 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_ifid_pipe
`default_nettype wire
